aes_block_collector: RTL and testbench

Downstream stage of the byte-serial AES core. Consumes the core's result byte stream (`output_valid`, `out_byte_num`, `data_out`) and assembles each set of 16 bytes into one 128-bit block. Completed blocks sit in a 2-entry buffer and are released through a valid/ready handshake. The block also tags each result with its encrypt/decrypt mode, raises a hold request toward the AES controller when the buffer is full, and flags incomplete blocks and overflow.

---
 rtl/aes_block_collector_if.sv | 26 ++
 rtl/aes_block_collector.sv | 91 +++++++++
 tb/tb_aes_block_collector.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_collector_if.sv
// Result-byte stream from the AES core in, assembled 128-bit blocks out.
// master drives the byte stream and consumer ready; slave is the collector.
interface aes_block_collector_if;
    logic         output_valid;
    logic [3:0]   out_byte_num;
    logic [7:0]   data_out;
    logic         in_encrypt;
    logic         clear_flags;
    logic         blk_ready;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_encrypt;
    logic [1:0]   blk_count;
    logic         hold;
    logic         err_incomplete;
    logic         overflow;

    modport master (
        output output_valid, out_byte_num, data_out, in_encrypt, clear_flags, blk_ready,
        input  blk_valid, blk_data, blk_encrypt, blk_count, hold, err_incomplete, overflow
    );
    modport slave (
        input  output_valid, out_byte_num, data_out, in_encrypt, clear_flags, blk_ready,
        output blk_valid, blk_data, blk_encrypt, blk_count, hold, err_incomplete, overflow
    );
endinterface

// File: rtl/aes_block_collector.sv
// Assembles the AES core's byte-serial results into 128-bit blocks and
// buffers them in a 2-entry FIFO released through a valid/ready handshake.
module aes_block_collector #(
    parameter int DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst,
    aes_block_collector_if.slave blk_if
);
    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [127:0] asm_data_q, asm_data_d;
    logic [15:0]  asm_mask_q, asm_mask_d;
    logic         asm_mode_q, asm_mode_d;
    logic [128:0] mem_q [DEPTH];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   cnt_q, cnt_d;
    logic         err_q, err_d, ovf_q, ovf_d;
    logic         push_req, set_err, pop, push_ok;
    logic [3:0]   lane;

    // Byte 0 lands in the top lane, byte 15 in the bottom lane.
    assign lane = 4'd15 - blk_if.out_byte_num;

    always_comb begin
        asm_data_d = asm_data_q;
        asm_mask_d = asm_mask_q;
        asm_mode_d = asm_mode_q;
        push_req   = 1'b0;
        set_err    = 1'b0;
        if (blk_if.output_valid) begin
            asm_data_d[{lane, 3'b000} +: 8] = blk_if.data_out;
            asm_mask_d[blk_if.out_byte_num]  = 1'b1;
            if (blk_if.out_byte_num == 4'd0) asm_mode_d = blk_if.in_encrypt;
            if (blk_if.out_byte_num == 4'd15) begin
                if (&(asm_mask_q | 16'h8000)) push_req = 1'b1;
                else                          set_err  = 1'b1;
                asm_mask_d = '0;
            end
        end
    end

    // A push into a full buffer only survives if the head leaves this cycle.
    assign pop     = (cnt_q != 2'd0) && blk_if.blk_ready;
    assign push_ok = push_req && ((cnt_q != FULL) || pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        err_d = set_err ? 1'b1 : (blk_if.clear_flags ? 1'b0 : err_q);
        ovf_d = (push_req && !push_ok) ? 1'b1 : (blk_if.clear_flags ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_data_q <= '0;
            asm_mask_q <= '0;
            asm_mode_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            asm_data_q <= asm_data_d;
            asm_mask_q <= asm_mask_d;
            asm_mode_q <= asm_mode_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {asm_mode_d, asm_data_d};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign blk_if.blk_valid      = (cnt_q != 2'd0);
    assign blk_if.blk_data       = mem_q[rd_ptr_q][127:0];
    assign blk_if.blk_encrypt    = mem_q[rd_ptr_q][128];
    assign blk_if.blk_count      = cnt_q;
    assign blk_if.hold           = (cnt_q == FULL);
    assign blk_if.err_incomplete = err_q;
    assign blk_if.overflow       = ovf_q;
endmodule

// File: tb/tb_aes_block_collector.sv
// Scoreboard bench for aes_block_collector: accepted blocks are queued when
// sent and compared as the consumer handshake pops them.
module tb_aes_block_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_block_collector_if bus ();
    aes_block_collector #(.DEPTH(2)) dut (.clk(clk), .rst(rst), .blk_if(bus));

    int errors = 0;
    int checks = 0;
    logic [128:0] sb_q [$];

    // Handshake monitor: the head observed at negedge with ready high is popped at the next edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.blk_valid === 1'b1 && bus.blk_ready === 1'b1) begin
            logic [128:0] exp;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got=%h required=none", {bus.blk_encrypt, bus.blk_data});
            end else begin
                exp = sb_q.pop_front();
                if ({bus.blk_encrypt, bus.blk_data} !== exp) begin
                    errors++;
                    $display("FAIL pop_block got=%h required=%h", {bus.blk_encrypt, bus.blk_data}, exp);
                end
            end
        end
    end

    function automatic logic [127:0] pack(input logic [7:0] b [16]);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = b[i];
        return r;
    endfunction

    task automatic send_byte(input logic [3:0] idx, input logic [7:0] val, input logic enc);
        bus.output_valid = 1'b1;
        bus.out_byte_num = idx;
        bus.data_out     = val;
        bus.in_encrypt   = enc;
        @(posedge clk); #1;
        bus.output_valid = 1'b0;
    endtask

    task automatic rand_block(output logic [7:0] b [16]);
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    endtask

    task automatic send_block(input logic [7:0] b [16], input logic enc, input bit accept);
        if (accept) sb_q.push_back({enc, pack(b)});
        for (int i = 0; i < 16; i++) send_byte(4'(i), b[i], enc);
    endtask

    task automatic pulse_clear();
        bus.clear_flags = 1'b1;
        @(posedge clk); #1;
        bus.clear_flags = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        bus.blk_ready = 1'b1;
        n = 0;
        while ((bus.blk_valid || sb_q.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        bus.blk_ready = 1'b0;
        checks++;
        if (bus.blk_valid !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain valid=%b pending=%0d required valid=0 pending=0", name, bus.blk_valid, sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({bus.blk_valid, bus.blk_count, bus.hold, bus.err_incomplete, bus.overflow, bus.blk_encrypt} !== 7'b0
            || bus.blk_data !== 128'h0) begin
            errors++;
            $display("FAIL reset_state v=%b c=%0d h=%b e=%b o=%b m=%b d=%h required all zero",
                     bus.blk_valid, bus.blk_count, bus.hold, bus.err_incomplete, bus.overflow, bus.blk_encrypt, bus.blk_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] b [16];
        for (int i = 0; i < 16; i++) b[i] = 8'(i);
        send_block(b, 1'b1, 1'b1);
        checks++;
        if (bus.blk_valid !== 1'b1 || bus.blk_data !== 128'h000102030405060708090A0B0C0D0E0F
            || bus.blk_encrypt !== 1'b1 || bus.blk_count !== 2'd1) begin
            errors++;
            $display("FAIL basic_block v=%b d=%h m=%b c=%0d required v=1 d=000102030405060708090a0b0c0d0e0f m=1 c=1",
                     bus.blk_valid, bus.blk_data, bus.blk_encrypt, bus.blk_count);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.blk_data !== 128'h000102030405060708090A0B0C0D0E0F || bus.blk_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_stable d=%h v=%b required held block", bus.blk_data, bus.blk_valid);
        end
        drain("basic");
    endtask

    task automatic test_overflow();
        logic [7:0] a [16], b [16], c [16];
        rand_block(a); rand_block(b); rand_block(c);
        send_block(a, 1'b1, 1'b1);
        send_block(b, 1'b0, 1'b1);
        checks++;
        if (bus.hold !== 1'b1 || bus.blk_count !== 2'd2) begin
            errors++;
            $display("FAIL full_hold hold=%b count=%0d required hold=1 count=2", bus.hold, bus.blk_count);
        end
        send_block(c, 1'b1, 1'b0);
        checks++;
        if (bus.overflow !== 1'b1 || bus.blk_count !== 2'd2 || bus.blk_data !== pack(a)) begin
            errors++;
            $display("FAIL overflow ovf=%b count=%0d head=%h required ovf=1 count=2 head=%h",
                     bus.overflow, bus.blk_count, bus.blk_data, pack(a));
        end
        bus.blk_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.blk_count !== 2'd1 || bus.hold !== 1'b0) begin
            errors++;
            $display("FAIL pop_first count=%0d hold=%b required count=1 hold=0", bus.blk_count, bus.hold);
        end
        @(posedge clk); #1;
        bus.blk_ready = 1'b0;
        checks++;
        if (bus.blk_count !== 2'd0 || bus.blk_valid !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL pop_second count=%0d valid=%b pending=%0d required 0 0 0", bus.blk_count, bus.blk_valid, sb_q.size());
        end
        pulse_clear();
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear ovf=%b required 0", bus.overflow);
        end
    endtask

    task automatic test_full_with_pop();
        logic [7:0] a [16], b [16], c [16];
        rand_block(a); rand_block(b); rand_block(c);
        send_block(a, 1'b0, 1'b1);
        send_block(b, 1'b1, 1'b1);
        sb_q.push_back({1'b1, pack(c)});
        for (int i = 0; i < 15; i++) send_byte(4'(i), c[i], 1'b1);
        bus.blk_ready = 1'b1;
        send_byte(4'd15, c[15], 1'b1);
        bus.blk_ready = 1'b0;
        checks++;
        if (bus.blk_count !== 2'd2 || bus.overflow !== 1'b0 || bus.blk_data !== pack(b)) begin
            errors++;
            $display("FAIL full_push_pop count=%0d ovf=%b head=%h required count=2 ovf=0 head=%h",
                     bus.blk_count, bus.overflow, bus.blk_data, pack(b));
        end
        drain("full_pop");
    endtask

    task automatic test_incomplete();
        logic [7:0] b [16];
        rand_block(b);
        for (int i = 0; i < 16; i++) if (i != 7) send_byte(4'(i), b[i], 1'b1);
        checks++;
        if (bus.err_incomplete !== 1'b1 || bus.blk_count !== 2'd0 || bus.blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL incomplete err=%b count=%0d valid=%b required err=1 count=0 valid=0",
                     bus.err_incomplete, bus.blk_count, bus.blk_valid);
        end
        rand_block(b);
        send_block(b, 1'b1, 1'b1);
        checks++;
        if (bus.blk_count !== 2'd1 || bus.blk_data !== pack(b)) begin
            errors++;
            $display("FAIL after_incomplete count=%0d d=%h required count=1 d=%h", bus.blk_count, bus.blk_data, pack(b));
        end
        drain("incomplete");
        pulse_clear();
        checks++;
        if (bus.err_incomplete !== 1'b0) begin
            errors++;
            $display("FAIL err_clear err=%b required 0", bus.err_incomplete);
        end
    endtask

    task automatic test_out_of_order();
        logic [7:0] b [16];
        int idx;
        rand_block(b);
        sb_q.push_back({1'b0, pack(b)});
        for (int i = 0; i < 15; i++) begin
            idx = (i * 7 + 3) % 15;
            send_byte(4'(idx), b[idx], (idx == 0) ? 1'b0 : 1'b1);
        end
        send_byte(4'd15, b[15], 1'b1);
        checks++;
        if (bus.blk_valid !== 1'b1 || bus.blk_encrypt !== 1'b0 || bus.blk_data !== pack(b)) begin
            errors++;
            $display("FAIL out_of_order v=%b m=%b d=%h required v=1 m=0 d=%h",
                     bus.blk_valid, bus.blk_encrypt, bus.blk_data, pack(b));
        end
        drain("ooo");
    endtask

    task automatic test_reset_mid_block();
        logic [7:0] b [16];
        rand_block(b);
        send_block(b, 1'b1, 1'b0);
        send_block(b, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(4'(i), 8'hAA, 1'b1);
        rst = 1'b1;
        #2;
        checks++;
        if (bus.blk_count !== 2'd0 || bus.blk_valid !== 1'b0 || bus.hold !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid count=%0d valid=%b hold=%b required 0 0 0", bus.blk_count, bus.blk_valid, bus.hold);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // Only the upper half is sent: a stale mask from before reset would complete it.
        for (int i = 8; i < 16; i++) send_byte(4'(i), b[i], 1'b1);
        checks++;
        if (bus.err_incomplete !== 1'b1 || bus.blk_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_stale_mask err=%b count=%0d required err=1 count=0", bus.err_incomplete, bus.blk_count);
        end
        pulse_clear();
        rand_block(b);
        send_block(b, 1'b0, 1'b1);
        checks++;
        if (bus.blk_data !== pack(b) || bus.blk_count !== 2'd1) begin
            errors++;
            $display("FAIL reset_new_block d=%h count=%0d required d=%h count=1", bus.blk_data, bus.blk_count, pack(b));
        end
        drain("reset");
    endtask

    initial begin
        bus.output_valid = 1'b0;
        bus.out_byte_num = 4'd0;
        bus.data_out     = 8'd0;
        bus.in_encrypt   = 1'b0;
        bus.clear_flags  = 1'b0;
        bus.blk_ready    = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_with_pop();
        test_incomplete();
        test_out_of_order();
        test_reset_mid_block();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
